// File: rtl/regfile_dump_if.sv
// Handshake and bus signals between the register-file dump engine and its
// environment: range request, register-file read port and the output stream.
interface regfile_dump_if #(
  parameter int addr_width = 1,
  parameter int data_width = 1
);
  logic                  START;
  logic [addr_width-1:0] RANGE_LO;
  logic [addr_width-1:0] RANGE_HI;
  logic                  ABORT;
  logic [addr_width-1:0] ADDR_RD;
  logic [data_width-1:0] D_RD;
  logic [data_width-1:0] DOUT;
  logic [addr_width-1:0] DOUT_ADDR;
  logic                  DOUT_VALID;
  logic                  DOUT_READY;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERR;
  logic [addr_width:0]   WORDS;

  modport slave (
    input  START, RANGE_LO, RANGE_HI, ABORT, D_RD, DOUT_READY,
    output ADDR_RD, DOUT, DOUT_ADDR, DOUT_VALID, BUSY, DONE, ERR, WORDS
  );

  modport master (
    output START, RANGE_LO, RANGE_HI, ABORT, D_RD, DOUT_READY,
    input  ADDR_RD, DOUT, DOUT_ADDR, DOUT_VALID, BUSY, DONE, ERR, WORDS
  );
endinterface

// File: rtl/regfile_dump.sv
// Streams an address range of a register file out through a 2-entry
// {address, data} FIFO with valid/ready flow control, abort and range checking.
module regfile_dump #(
  parameter int addr_width = 1,
  parameter int data_width = 1,
  parameter int lo         = 0,
  parameter int hi         = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  regfile_dump_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int EW = addr_width + data_width;
  localparam logic [addr_width-1:0]        LO_A = addr_width'(lo);
  localparam logic signed [addr_width+1:0] LO_S = (addr_width+2)'(lo);
  localparam logic signed [addr_width+1:0] HI_S = (addr_width+2)'(hi);

  // Widened signed compare keeps the bounds test meaningful for any lo/hi.
  function automatic logic range_ok(input logic [addr_width-1:0] a,
                                    input logic [addr_width-1:0] b);
    logic signed [addr_width+1:0] sa;
    logic signed [addr_width+1:0] sb;
    sa = $signed({2'b00, a});
    sb = $signed({2'b00, b});
    return (sa >= LO_S) && (sa <= sb) && (sb <= HI_S);
  endfunction

  logic [1:0]            state;
  logic [addr_width-1:0] ptr;
  logic [addr_width-1:0] last;
  logic [1:0]            count;
  logic [1:0]            count_nx;
  logic                  rd_idx;
  logic                  wr_idx;
  logic                  done_q;
  logic                  err_q;
  logic [addr_width:0]   words;
  logic [EW-1:0]         mem [2];
  logic                  pop;
  logic                  push;

  assign pop      = (count != 2'd0) && bus.DOUT_READY;
  assign push     = (state == RUN) && ((count != 2'd2) || pop);
  assign count_nx = count + {1'b0, push} - {1'b0, pop};

  assign bus.ADDR_RD               = (state == RUN) ? ptr : LO_A;
  assign {bus.DOUT_ADDR, bus.DOUT} = mem[rd_idx];
  assign bus.DOUT_VALID            = (count != 2'd0);
  assign bus.BUSY                  = (state != IDLE);
  assign bus.DONE                  = done_q;
  assign bus.ERR                   = err_q;
  assign bus.WORDS                 = words;

  // Control: FSM, FIFO occupancy, pointer and word counter
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      ptr    <= LO_A;
      count  <= 2'd0;
      rd_idx <= 1'b0;
      wr_idx <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      words  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state == IDLE) begin
        if (bus.START) begin
          if (range_ok(bus.RANGE_LO, bus.RANGE_HI)) begin
            ptr   <= bus.RANGE_LO;
            words <= '0;
            state <= RUN;
          end else begin
            err_q <= 1'b1;
          end
        end
      end else if (bus.ABORT) begin
        state  <= IDLE;
        count  <= 2'd0;
        rd_idx <= 1'b0;
        wr_idx <= 1'b0;
      end else begin
        count <= count_nx;
        if (pop) begin
          rd_idx <= ~rd_idx;
          words  <= words + 1'b1;
        end
        if (push) begin
          wr_idx <= ~wr_idx;
          // Stop at the last address without incrementing, so no wrap.
          if (ptr == last) state <= DRAIN;
          else             ptr   <= ptr + 1'b1;
        end
        if ((state == DRAIN) && (count_nx == 2'd0)) begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
      end
    end
  end

  // Data: FIFO storage and latched range end, no reset needed
  always_ff @(posedge CLK) begin
    if ((state == IDLE) && bus.START) last <= bus.RANGE_HI;
    if (push && !bus.ABORT) mem[wr_idx] <= {ptr, bus.D_RD};
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: 4-bit address, 8-bit data, register file
// modelled as arr[i] = 8'h10 + i.
module tb_regfile_dump;
  logic CLK;
  logic RST_N;
  int   tests;
  int   fails;

  regfile_dump_if #(.addr_width(4), .data_width(8)) bus ();

  regfile_dump #(.addr_width(4), .data_width(8), .lo(0), .hi(15)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  assign bus.D_RD = 8'h10 + {4'h0, bus.ADDR_RD};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic v, input logic b,
                         input logic d, input logic e);
    chk({tag, "_valid"}, 32'(bus.DOUT_VALID), 32'(v));
    chk({tag, "_busy"},  32'(bus.BUSY),       32'(b));
    chk({tag, "_done"},  32'(bus.DONE),       32'(d));
    chk({tag, "_err"},   32'(bus.ERR),        32'(e));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [3:0] rlo, input logic [3:0] rhi);
    bus.START    = 1'b1;
    bus.RANGE_LO = rlo;
    bus.RANGE_HI = rhi;
    step();
    bus.START    = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_a;
    logic       stalled;
    logic       done_seen;
    logic [3:0] sv_addr;
    logic [7:0] sv_data;
    logic       rdy;

    tests = 0;
    fails = 0;
    RST_N = 1'b0;
    bus.START = 1'b0;
    bus.RANGE_LO = 4'h0;
    bus.RANGE_HI = 4'h0;
    bus.ABORT = 1'b0;
    bus.DOUT_READY = 1'b0;
    step();
    step();
    chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_words", 32'(bus.WORDS), 32'd0);
    chk("rst_addr_rd", 32'(bus.ADDR_RD), 32'd0);
    RST_N = 1'b1;
    step();

    // Range 2..5, ready held high: one word per cycle from t+2
    bus.DOUT_READY = 1'b1;
    start(4'd2, 4'd5);
    chk_ctl("a_t1", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("a_t1_addr_rd", 32'(bus.ADDR_RD), 32'd2);
    chk("a_t1_words", 32'(bus.WORDS), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("a_valid", 32'(bus.DOUT_VALID), 32'd1);
      chk("a_addr", 32'(bus.DOUT_ADDR), 32'(2 + i));
      chk("a_data", 32'(bus.DOUT), 32'(8'h12 + i));
      chk("a_done_early", 32'(bus.DONE), 32'd0);
      step();
    end
    chk_ctl("a_end", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("a_words", 32'(bus.WORDS), 32'd4);
    chk("a_addr_rd_idle", 32'(bus.ADDR_RD), 32'd0);
    step();
    chk("a_done_pulse", 32'(bus.DONE), 32'd0);

    // Range 0..15 with ready toggling: order, no loss/dup, stall stability
    start(4'd0, 4'd15);
    exp_a = 5'd0;
    stalled = 1'b0;
    done_seen = 1'b0;
    rdy = 1'b1;
    sv_addr = 4'h0;
    sv_data = 8'h00;
    for (int c = 0; c < 80 && !done_seen; c++) begin
      bus.DOUT_READY = rdy;
      #1;
      if (bus.DONE) begin
        done_seen = 1'b1;
      end else begin
        if (stalled) begin
          chk("b_stable_addr", 32'(bus.DOUT_ADDR), 32'(sv_addr));
          chk("b_stable_data", 32'(bus.DOUT), 32'(sv_data));
        end
        stalled = 1'b0;
        if (bus.DOUT_VALID && rdy) begin
          chk("b_addr", 32'(bus.DOUT_ADDR), 32'(exp_a));
          chk("b_data", 32'(bus.DOUT), 32'(8'h10 + exp_a));
          exp_a = exp_a + 5'd1;
        end else if (bus.DOUT_VALID) begin
          stalled = 1'b1;
          sv_addr = bus.DOUT_ADDR;
          sv_data = bus.DOUT;
        end
        step();
        rdy = ~rdy;
      end
    end
    chk("b_done_seen", 32'(done_seen), 32'd1);
    chk("b_count", 32'(exp_a), 32'd16);
    chk("b_words", 32'(bus.WORDS), 32'd16);
    chk("b_busy", 32'(bus.BUSY), 32'd0);

    // Single address at the top of the range: exactly one word, no wrap
    bus.DOUT_READY = 1'b1;
    start(4'd15, 4'd15);
    chk("c_t1_addr_rd", 32'(bus.ADDR_RD), 32'd15);
    chk("c_t1_valid", 32'(bus.DOUT_VALID), 32'd0);
    step();
    chk("c_valid", 32'(bus.DOUT_VALID), 32'd1);
    chk("c_addr", 32'(bus.DOUT_ADDR), 32'hF);
    chk("c_data", 32'(bus.DOUT), 32'h1F);
    step();
    chk_ctl("c_end", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("c_words", 32'(bus.WORDS), 32'd1);
    step();
    chk_ctl("c_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Illegal range 9..3 is rejected
    start(4'd9, 4'd3);
    chk_ctl("d_err", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_ctl("d_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("d_words_held", 32'(bus.WORDS), 32'd1);

    // ABORT while idle does nothing
    bus.ABORT = 1'b1;
    step();
    bus.ABORT = 1'b0;
    chk_ctl("idle_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_abort_words", 32'(bus.WORDS), 32'd1);

    // Range 0..7: three pops, stall until FIFO full, then ABORT
    bus.DOUT_READY = 1'b1;
    start(4'd0, 4'd7);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("e_addr", 32'(bus.DOUT_ADDR), 32'(i));
      step();
    end
    bus.DOUT_READY = 1'b0;
    step();
    chk("e_full_valid", 32'(bus.DOUT_VALID), 32'd1);
    chk("e_full_head", 32'(bus.DOUT_ADDR), 32'd3);
    chk("e_words3", 32'(bus.WORDS), 32'd3);
    bus.ABORT = 1'b1;
    bus.DOUT_READY = 1'b1;
    step();
    bus.ABORT = 1'b0;
    chk_ctl("e_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("e_words", 32'(bus.WORDS), 32'd3);
    step();
    chk_ctl("e_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in RUN with data pending, then a normal dump
    bus.DOUT_READY = 1'b0;
    start(4'd0, 4'd7);
    step();
    chk("f_valid_pre", 32'(bus.DOUT_VALID), 32'd1);
    RST_N = 1'b0;
    step();
    chk_ctl("f_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("f_rst_words", 32'(bus.WORDS), 32'd0);
    chk("f_rst_addr_rd", 32'(bus.ADDR_RD), 32'd0);
    RST_N = 1'b1;
    step();
    chk_ctl("f_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.DOUT_READY = 1'b1;
    start(4'd4, 4'd4);
    chk("f_t1_addr_rd", 32'(bus.ADDR_RD), 32'd4);
    step();
    chk("f_addr", 32'(bus.DOUT_ADDR), 32'd4);
    chk("f_data", 32'(bus.DOUT), 32'h14);
    step();
    chk_ctl("f_end", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("f_words", 32'(bus.WORDS), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter addr_width, default 1, meaning register-file address width.
REQ-002 SHALL have parameter data_width, default 1, meaning register-file data width.
REQ-003 SHALL have parameter lo, default 0, meaning lowest legal address.
REQ-004 SHALL have parameter hi, default 1, meaning highest legal address.
REQ-005 SHALL use one clock and a synchronous, active-low reset: CLK  in  1  clock, all state updates on posedge.
REQ-006 SHALL have RST_N  in  1  synchronous active-low reset.
REQ-007 SHALL have START  in  1  request to begin a dump, sampled in IDLE only.
REQ-008 SHALL have RANGE_LO  in  addr_width  first address to dump, sampled with START.
REQ-009 SHALL have RANGE_HI  in  addr_width  last address to dump, sampled with START.
REQ-010 SHALL have ABORT  in  1  cancel the current dump.
REQ-011 SHALL have ADDR_RD  out  addr_width  address driven to a register-file read port.
REQ-012 SHALL have D_RD  in  data_width  combinational read data returned for ADDR_RD.
REQ-013 SHALL have DOUT  out  data_width  streamed word.
REQ-014 SHALL have DOUT_ADDR  out  addr_width  address of DOUT.
REQ-015 SHALL have DOUT_VALID  out  1  DOUT/DOUT_ADDR are valid.
REQ-016 SHALL have DOUT_READY  in  1  consumer accepts the word.
REQ-017 SHALL have BUSY  out  1  high in RUN or DRAIN.
REQ-018 SHALL have DONE  out  1  one-cycle pulse on normal completion.
REQ-019 SHALL have ERR  out  1  one-cycle pulse on a rejected START.
REQ-020 SHALL have WORDS  out  addr_width+1  count of words transferred since the last accepted START.

Function
REQ-021 SHALL implement the states IDLE, RUN and DRAIN.
REQ-022 In IDLE, START=1 with lo<=RANGE_LO<=RANGE_HI<=hi SHALL latch the range, clear WORDS and enter RUN next cycle.
REQ-023 In IDLE, START=1 with an illegal range SHALL pulse ERR the next cycle and remain in IDLE.
REQ-024 START SHALL be ignored in RUN and DRAIN.
REQ-025 SHALL contain a 2-entry output FIFO holding {address, data}, with DOUT/DOUT_ADDR taken from the head and DOUT_VALID = not empty.
REQ-026 A pop SHALL occur when DOUT_VALID && DOUT_READY.
REQ-027 DOUT and DOUT_ADDR SHALL stay stable while DOUT_VALID && !DOUT_READY.
REQ-028 In RUN, ADDR_RD SHALL equal the read pointer.
REQ-029 A push of {ptr, D_RD} SHALL occur when the FIFO count < 2 or a pop occurs in the same cycle.
REQ-030 On a push the read pointer SHALL increment.
REQ-031 A push at ptr == RANGE_HI SHALL move to DRAIN and SHALL NOT increment the pointer, so no wrap occurs even when RANGE_HI is all ones.
REQ-032 Latency: START accepted in cycle t SHALL give ADDR_RD=RANGE_LO in t+1 and the first DOUT_VALID in t+2.
REQ-033 With DOUT_READY held high, throughput SHALL be one word per cycle.
REQ-034 In DRAIN, once the FIFO becomes empty, DONE SHALL pulse for one cycle (coincident with the return to IDLE) and the state SHALL return to IDLE.
REQ-035 A single-address range (RANGE_LO == RANGE_HI) SHALL produce exactly one word, then DONE.
REQ-036 ABORT in RUN or DRAIN SHALL flush the FIFO, deassert DOUT_VALID and return to IDLE next cycle with no DONE pulse.
REQ-037 ABORT SHALL take priority over a push or pop in the same cycle.
REQ-038 ABORT in IDLE SHALL have no effect.
REQ-039 WORDS SHALL increment on every pop, hold its value in IDLE and be cleared only by an accepted START.
REQ-040 In IDLE, ADDR_RD SHALL equal lo.

Reset
REQ-041 RST_N=0 at a clock edge SHALL force IDLE, empty the FIFO and set DOUT_VALID=0, BUSY=0, DONE=0, ERR=0, WORDS=0 and ADDR_RD=lo.
REQ-042 Reset asserted mid-dump SHALL behave exactly as REQ-041, with no DONE pulse.
REQ-043 DOUT and DOUT_ADDR values while DOUT_VALID=0 SHALL be don't-care.

Verification (addr_width=4, data_width=8, lo=0, hi=15, bench register file arr[i]=8'h10+i)
REQ-044 SHALL cover: START with range 2..5 and DOUT_READY=1 -> words {2,12},{3,13},{4,14},{5,15} on four consecutive cycles starting t+2, DONE one cycle after the last pop, WORDS=4.
REQ-045 SHALL cover: range 0..15 with DOUT_READY toggling 1,0,1,0 -> all 16 words in order, none duplicated or lost, DOUT stable while stalled, WORDS=16.
REQ-046 SHALL cover: range 15..15 -> single word {F,1F}, DONE pulse, pointer does not wrap to 0.
REQ-047 SHALL cover: START with RANGE_LO=9, RANGE_HI=3 -> ERR pulse, BUSY stays 0, no DOUT_VALID.
REQ-048 SHALL cover: range 0..7 with ABORT after the 3rd pop and the FIFO full -> DOUT_VALID=0 next cycle, IDLE, no DONE, WORDS=3.
REQ-049 SHALL cover: RST_N=0 during RUN with DOUT_VALID=1 -> all outputs at reset values next cycle, and a subsequent START works normally.
